// File: rtl/pes_pkg.sv
// Shared configuration for the DRR packet egress scheduler: default sizes,
// FSM state encoding and the traffic-class index type.
package pes_pkg;

   localparam int NUM_TC = 8;   // traffic classes
   localparam int LENW   = 14;  // packet length width, bytes
   localparam int QW     = 14;  // per-TC quantum width
   localparam int DCW    = 16;  // per-TC deficit counter width

   typedef enum logic [1:0] {
      ST_ADD   = 2'd0,
      ST_CHECK = 2'd1,
      ST_GRANT = 2'd2
   } state_t;

   typedef logic [$clog2(NUM_TC)-1:0] tc_idx_t;

endpackage

// File: rtl/pes_drr_sched_if.sv
// Grant handshake between the scheduler (master) and the transmit
// controller (slave).
interface pes_drr_sched_if #(
   parameter int NUM_TC = 8,
   parameter int LENW   = 14
) ();

   logic                      grant_valid;
   logic [$clog2(NUM_TC)-1:0] grant_tc;
   logic [LENW-1:0]           grant_len;
   logic                      grant_ready;

   modport master (
      output grant_valid,
      output grant_tc,
      output grant_len,
      input  grant_ready
   );

   modport slave (
      input  grant_valid,
      input  grant_tc,
      input  grant_len,
      output grant_ready
   );

endinterface

// File: rtl/pes_drr_deficit.sv
// Per-TC deficit register file. One TC is addressed per cycle; clear wins
// over subtract, subtract wins over add. Add saturates at all-ones.
// Assumes QW <= DCW and LENW < DCW.
module pes_drr_deficit #(
   parameter int NUM_TC = 8,
   parameter int LENW   = 14,
   parameter int QW     = 14,
   parameter int DCW    = 16
) (
   input  logic                      clk,
   input  logic                      arst_n,
   input  logic [$clog2(NUM_TC)-1:0] i_idx,
   input  logic                      i_add_en,
   input  logic [QW-1:0]             i_quantum,
   input  logic                      i_sub_en,
   input  logic [LENW-1:0]           i_sub_len,
   input  logic                      i_clr_en,
   output logic [NUM_TC*DCW-1:0]     o_deficit
);

   logic [DCW-1:0] r_def [NUM_TC];

   function automatic logic [DCW-1:0] sat_add(input logic [DCW-1:0] a,
                                              input logic [QW-1:0]  b);
      logic [DCW:0] sum;
      sum = {1'b0, a} + {{(DCW+1-QW){1'b0}}, b};
      if (sum[DCW]) begin
         sat_add = {DCW{1'b1}};
      end else begin
         sat_add = sum[DCW-1:0];
      end
   endfunction

   // Deficit update for the addressed TC; reset clears every counter.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         for (int i = 0; i < NUM_TC; i++) begin
            r_def[i] <= {DCW{1'b0}};
         end
      end else if (i_clr_en) begin
         r_def[i_idx] <= {DCW{1'b0}};
      end else if (i_sub_en) begin
         r_def[i_idx] <= r_def[i_idx] - {{(DCW-LENW){1'b0}}, i_sub_len};
      end else if (i_add_en) begin
         r_def[i_idx] <= sat_add(r_def[i_idx], i_quantum);
      end
   end

   for (genvar g = 0; g < NUM_TC; g++) begin : g_flat
      assign o_deficit[g*DCW +: DCW] = r_def[g];
   end

endmodule

// File: rtl/pes_drr_sched.sv
// Deficit-round-robin scheduler over NUM_TC traffic classes with PFC pause.
// Optional feature macro PES_STRICT_PRIO_EN: the highest TC (NUM_TC-1) is
// served with strict priority and leaves the DRR rotation.
module pes_drr_sched
   import pes_pkg::*;
#(
   parameter int NUM_TC = pes_pkg::NUM_TC,
   parameter int LENW   = pes_pkg::LENW,
   parameter int QW     = pes_pkg::QW,
   parameter int DCW    = pes_pkg::DCW
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic [NUM_TC-1:0]      tc_valid,
   input  logic [NUM_TC*LENW-1:0] tc_len,
   input  logic [NUM_TC-1:0]      pfc_pause,
   input  logic [NUM_TC*QW-1:0]   cfg_quantum,
   pes_drr_sched_if.master        gnt,
   output logic                   idle
);

   localparam int TCW = $clog2(NUM_TC);
`ifdef PES_STRICT_PRIO_EN
   localparam logic [TCW-1:0] PRIO_IDX = TCW'(NUM_TC-1);
   localparam logic [TCW-1:0] WRAP_IDX = TCW'(NUM_TC-2);
`else
   localparam logic [TCW-1:0] WRAP_IDX = TCW'(NUM_TC-1);
`endif

   state_t              r_state;
   logic [TCW-1:0]      r_ptr;
   logic                r_grant_valid;
   logic [TCW-1:0]      r_grant_tc;
   logic [LENW-1:0]     r_grant_len;
   logic                r_strict;      // current grant came from the priority TC

   logic [NUM_TC-1:0]     w_elig;
   logic [NUM_TC*DCW-1:0] w_deficit;
   logic [DCW-1:0]        w_cur_def;
   logic [LENW-1:0]       w_cur_len;
   logic [QW-1:0]         w_cur_q;
   logic                  w_len_ok;
   logic                  w_strict_hit;
   logic [TCW-1:0]        w_ptr_nxt;
   logic                  w_add_en;
   logic                  w_sub_en;
   logic                  w_clr_en;

   assign w_elig    = tc_valid & ~pfc_pause;
   assign w_cur_def = w_deficit[r_ptr*DCW +: DCW];
   assign w_cur_len = tc_len[r_ptr*LENW +: LENW];
   assign w_cur_q   = cfg_quantum[r_ptr*QW +: QW];
   assign w_len_ok  = (w_cur_def >= {{(DCW-LENW){1'b0}}, w_cur_len});

`ifdef PES_STRICT_PRIO_EN
   logic [LENW-1:0] w_prio_len;
   assign w_prio_len   = tc_len[(NUM_TC-1)*LENW +: LENW];
   assign w_strict_hit = (r_state == ST_CHECK) & w_elig[NUM_TC-1];
`else
   assign w_strict_hit = 1'b0;
`endif

   // A strict-priority grant leaves the rotating TC's deficit untouched.
   assign w_add_en = (r_state == ST_ADD) & w_elig[r_ptr];
   assign w_clr_en = (r_state == ST_CHECK) & ~w_strict_hit & ~tc_valid[r_ptr];
   assign w_sub_en = (r_state == ST_GRANT) & gnt.grant_ready & ~r_strict;

   // Next rotation pointer, wrapping at the last DRR-scheduled TC.
   always_comb begin
      w_ptr_nxt = r_ptr + {{(TCW-1){1'b0}}, 1'b1};
      if (r_ptr == WRAP_IDX) begin
         w_ptr_nxt = {TCW{1'b0}};
      end else begin
         w_ptr_nxt = r_ptr + {{(TCW-1){1'b0}}, 1'b1};
      end
   end

   pes_drr_deficit #(
      .NUM_TC (NUM_TC),
      .LENW   (LENW),
      .QW     (QW),
      .DCW    (DCW)
   ) u_deficit (
      .clk       (clk),
      .arst_n    (arst_n),
      .i_idx     (r_ptr),
      .i_add_en  (w_add_en),
      .i_quantum (w_cur_q),
      .i_sub_en  (w_sub_en),
      .i_sub_len (r_grant_len),
      .i_clr_en  (w_clr_en),
      .o_deficit (w_deficit)
   );

   // ADD/CHECK/GRANT sequencer with registered grant outputs.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_state       <= ST_ADD;
         r_ptr         <= {TCW{1'b0}};
         r_grant_valid <= 1'b0;
         r_grant_tc    <= {TCW{1'b0}};
         r_grant_len   <= {LENW{1'b0}};
         r_strict      <= 1'b0;
      end else begin
         case (r_state)
            ST_ADD: begin
               r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (w_strict_hit) begin
`ifdef PES_STRICT_PRIO_EN
                  r_grant_tc  <= PRIO_IDX;
                  r_grant_len <= w_prio_len;
`endif
                  r_grant_valid <= 1'b1;
                  r_strict      <= 1'b1;
                  r_state       <= ST_GRANT;
               end else if (w_elig[r_ptr] && w_len_ok) begin
                  r_grant_valid <= 1'b1;
                  r_grant_tc    <= r_ptr;
                  r_grant_len   <= w_cur_len;
                  r_strict      <= 1'b0;
                  r_state       <= ST_GRANT;
               end else begin
                  r_ptr   <= w_ptr_nxt;
                  r_state <= ST_ADD;
               end
            end
            ST_GRANT: begin
               if (gnt.grant_ready) begin
                  r_grant_valid <= 1'b0;
                  r_state       <= ST_CHECK;
               end
            end
            default: begin
               r_state       <= ST_ADD;
               r_grant_valid <= 1'b0;
            end
         endcase
      end
   end

   assign gnt.grant_valid = r_grant_valid;
   assign gnt.grant_tc    = r_grant_tc;
   assign gnt.grant_len   = r_grant_len;

   assign idle = ~|w_elig & ~r_grant_valid;

endmodule
